// File: rtl/distributor14_if.sv
// distributor14_if: source handshake plus four consumer channels of the 1-to-4 distributor
interface distributor14_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] iData;
  logic [1:0]       iS;
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] oZ0;
  logic [WIDTH-1:0] oZ1;
  logic [WIDTH-1:0] oZ2;
  logic [WIDTH-1:0] oZ3;
  logic [3:0]       oValid;
  logic [3:0]       iReady;
  modport master (output iData, iS, iValid, iReady, input oReady, oZ0, oZ1, oZ2, oZ3, oValid);
  modport slave (input iData, iS, iValid, iReady, output oReady, oZ0, oZ1, oZ2, oZ3, oValid);
endinterface

// File: rtl/distributor14.sv
// distributor14: steers one valid/ready stream into four 2-entry first-word-fall-through channels
module distributor14 #(parameter int WIDTH = 32) (
  input logic iClk,
  input logic iRst,
  distributor14_if.slave bus
);
  logic [WIDTH-1:0] mem_q [4][2];
  logic [1:0] cnt_q [4];
  logic [1:0] cnt_d [4];
  logic [3:0] wp_q, rp_q, push, pop;
  // Readiness depends only on the selected channel's occupancy, never on iReady or iValid
  assign bus.oReady = cnt_q[bus.iS] != 2'd2;
  assign bus.oZ0 = mem_q[0][rp_q[0]];
  assign bus.oZ1 = mem_q[1][rp_q[1]];
  assign bus.oZ2 = mem_q[2][rp_q[2]];
  assign bus.oZ3 = mem_q[3][rp_q[3]];
  // Per-channel push/pop decode and next occupancy
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      push[k] = bus.iValid & bus.oReady & (bus.iS == 2'(k));
      pop[k] = (cnt_q[k] != 2'd0) & bus.iReady[k];
      cnt_d[k] = cnt_q[k] + 2'(push[k]) - 2'(pop[k]);
      bus.oValid[k] = cnt_q[k] != 2'd0;
    end
  end
  // Buffer storage, 1-bit pointers toggle to wrap, reset clears everything
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
        mem_q[k][0] <= '0;
        mem_q[k][1] <= '0;
      end
    end else begin
      wp_q <= wp_q ^ push;
      rp_q <= rp_q ^ pop;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (push[k]) mem_q[k][wp_q[k]] <= bus.iData;
      end
    end
  end
endmodule

// File: tb/tb_distributor14.sv
// tb_distributor14: directed and random checks of distributor14 against a per-channel queue model
module tb_distributor14;
  logic iClk = 0;
  logic iRst = 1;
  logic en = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] q [4][$];
  logic [31:0] z [4];
  distributor14_if #(.WIDTH(32)) bus ();
  distributor14 #(.WIDTH(32)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
  always #5 iClk = ~iClk;
  assign z[0] = bus.oZ0;
  assign z[1] = bus.oZ1;
  assign z[2] = bus.oZ2;
  assign z[3] = bus.oZ3;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  // Reference model: each channel is a queue of at most two words
  always @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      logic acc;
      acc = bus.iValid && q[bus.iS].size() != 2;
      for (int k = 0; k < 4; k++)
        if (q[k].size() != 0 && bus.iReady[k]) void'(q[k].pop_front());
      if (acc) q[bus.iS].push_back(bus.iData);
    end
  end
  // Every cycle: compare valid flags, head words and readiness against the model
  always @(negedge iClk) begin
    if (en) begin
      logic [3:0] v;
      for (int k = 0; k < 4; k++) begin
        v[k] = q[k].size() != 0;
        if (v[k]) chk($sformatf("oZ%0d", k), z[k], q[k][0]);
      end
      chk("oValid", 32'(bus.oValid), 32'(v));
      chk("oReady", 32'(bus.oReady), 32'(q[bus.iS].size() != 2));
    end
  end
  task automatic cyc(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    bus.iValid = v;
    bus.iS = s;
    bus.iData = d;
    bus.iReady = r;
    @(posedge iClk);
    #1;
  endtask
  initial begin
    cyc(1, 2, 32'hDEADBEEF, 4'b0000);
    cyc(1, 2, 32'hDEADBEEF, 4'b0000);
    iRst = 0;
    en = 1;
    bus.iValid = 0;
    chk("rst_oValid", 32'(bus.oValid), 0);
    chk("rst_oZ0", bus.oZ0, 0);
    chk("rst_oZ1", bus.oZ1, 0);
    chk("rst_oZ2", bus.oZ2, 0);
    chk("rst_oZ3", bus.oZ3, 0);
    for (int s = 0; s < 4; s++) begin
      bus.iS = 2'(s);
      #1;
      chk("rst_oReady", 32'(bus.oReady), 1);
    end
    cyc(1, 0, 32'h11111111, 4'b0000);
    chk("r_v0", 32'(bus.oValid), 32'h1);
    chk("r_z0", bus.oZ0, 32'h11111111);
    cyc(1, 1, 32'h22222222, 4'b0000);
    chk("r_v1", 32'(bus.oValid), 32'h3);
    chk("r_z1", bus.oZ1, 32'h22222222);
    cyc(1, 2, 32'h33333333, 4'b0000);
    chk("r_v2", 32'(bus.oValid), 32'h7);
    chk("r_z2", bus.oZ2, 32'h33333333);
    cyc(1, 3, 32'h44444444, 4'b0000);
    chk("r_v3", 32'(bus.oValid), 32'hF);
    chk("r_z3", bus.oZ3, 32'h44444444);
    cyc(0, 0, 0, 4'b1111);
    chk("drain", 32'(bus.oValid), 0);
    cyc(1, 2, 32'hA0, 4'b0000);
    cyc(1, 2, 32'hA1, 4'b0000);
    bus.iData = 32'hA2;
    #1;
    chk("bp_full", 32'(bus.oReady), 0);
    cyc(1, 2, 32'hA2, 4'b0000);
    chk("bp_hold", bus.oZ2, 32'hA0);
    chk("bp_still_full", 32'(bus.oReady), 0);
    cyc(1, 2, 32'hA2, 4'b0100);
    chk("bp_pop", bus.oZ2, 32'hA1);
    chk("bp_free", 32'(bus.oReady), 1);
    cyc(1, 2, 32'hA2, 4'b0000);
    chk("bp_refull", 32'(bus.oReady), 0);
    cyc(0, 2, 0, 4'b0100);
    chk("bp_a2", bus.oZ2, 32'hA2);
    cyc(0, 2, 0, 4'b0100);
    chk("bp_empty", 32'(bus.oValid), 0);
    for (int i = 1; i <= 100; i++) begin
      bus.iValid = 1;
      bus.iS = 1;
      bus.iData = 32'(i);
      bus.iReady = 4'b0010;
      #1;
      chk("pt_ready", 32'(bus.oReady), 1);
      @(posedge iClk);
      #1;
      chk("pt_z1", bus.oZ1, 32'(i));
      chk("pt_v", 32'(bus.oValid), 32'h2);
    end
    cyc(0, 1, 0, 4'b0010);
    chk("pt_empty", 32'(bus.oValid), 0);
    cyc(1, 3, 32'h55, 4'b0000);
    cyc(1, 0, 32'hC0, 4'b0000);
    cyc(1, 0, 32'hC1, 4'b0000);
    cyc(1, 3, 32'h66, 4'b1001);
    chk("sim_z3", bus.oZ3, 32'h66);
    chk("sim_v", 32'(bus.oValid), 32'h9);
    chk("sim_z0", bus.oZ0, 32'hC1);
    cyc(0, 0, 0, 4'b1001);
    chk("sim_empty", 32'(bus.oValid), 0);
    for (int c = 0; c < 10000; c++) begin
      iRst = c == 5000;
      cyc(1'($urandom_range(0, 1)), 2'($urandom), $urandom, 4'($urandom));
      if (c == 5000) begin
        chk("soak_rst_v", 32'(bus.oValid), 0);
        chk("soak_rst_q", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 0);
      end
    end
    iRst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/distributor14.md
# distributor14

Registered 1-to-4 data distributor with a valid/ready handshake: one 32-bit source stream is steered by a 2-bit select into one of four output channels, each with a 2-entry first-word-fall-through buffer. It is the write-side counterpart of the 4:1 selectors in the datapath. It fans a single producer (e.g. the write-back/result bus) out to four independent consumers that may stall independently. Each channel preserves arrival order.

## Interface
- WIDTH, 32, data width of input and every output channel.
- iClk  input  1  clock; all state changes on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iData  input  WIDTH  source data word.
- iS  input  2  destination channel select (0..3), sampled with iData.
- iValid  input  1  source presents a word.
- oReady  output  1  destination channel iS can accept this cycle.
- oZ0, oZ1, oZ2, oZ3  output  WIDTH each  head word of channel 0..3.
- oValid  output  4  bit k: channel k head word valid.
- iReady  input  4  bit k: consumer k takes the head word this cycle.

## Operation
- Per channel k: 2-entry buffer, 2-bit occupancy count cnt[k] (0..2), 1-bit read and write pointers.
- oReady = (cnt[iS] != 2). Purely combinational from iS and registered state. No path from iReady or iValid.
- Push to channel k: iValid & oReady & (iS == k). Writes iData at the write pointer, advances it (wraps 1->0), cnt[k] += 1.
- Pop from channel k: oValid[k] & iReady[k]. Advances the read pointer (wraps), cnt[k] -= 1. iReady[k] while oValid[k]=0 is ignored.
- Push and pop on the same channel in the same cycle (cnt=1): cnt unchanged, both pointers advance.
- At cnt=0, a push and no pop yield cnt=1. A pop is impossible at cnt=0.
- At cnt=2, oReady=0 when iS selects k, even if iReady[k]=1 in the same cycle. Space frees on the next cycle.
- oValid[k] = (cnt[k] != 0).
- oZk = buffer entry at the read pointer. When cnt[k]=0, oZk holds the last popped value and is don't-care to consumers.
- Channels are fully independent. Pops on all four channels and a push to one may all occur in one cycle.
- iS with iValid=0 only affects oReady; no state change.
- Data is never dropped or duplicated. Per-channel output order equals acceptance order.

## Timing
- Reset (iRst=1 at rising edge) sets:
  - all cnt to 0, all pointers to 0, all buffer entries to 0.
  - After the edge: oValid=4'b0000, oZ0..oZ3=0, oReady=1 for any iS.
- Reset overrides any simultaneous push or pop. Words in flight mid-operation are discarded.
- Latency: a word accepted at edge N is on oZk with oValid[k]=1 after edge N, if the channel was empty. Otherwise it appears behind earlier words.
- Throughput: 1 word/cycle per channel sustained when the consumer holds iReady[k]=1.
- A consumer stalled for 2+ cycles back-pressures only pushes targeting its channel.

## Test plan
- Reset:
  - Stimulus: assert iRst for 2 cycles with iValid=1, iS=2, iData=32'hDEADBEEF.
  - Required: after release, oValid=0000, oZ0..3=0, oReady=1. No word captured.
- Single routing:
  - Stimulus: push 32'h11111111 with iS=0, 32'h22222222 with iS=1, 32'h33333333 with iS=2, 32'h44444444 with iS=3 on consecutive cycles, iReady=0000.
  - Required: oValid rises on bits 0,1,2,3 one cycle after each push. oZk equals the corresponding word.
- Full/back-pressure:
  - Stimulus: iReady[2]=0, push 32'hA0, 32'hA1, 32'hA2 to channel 2.
  - Required: first two accepted; oReady=0 on the third and it is held.
  - Stimulus: raise iReady[2] for 1 cycle.
  - Required: oZ2 changes A0->A1. oReady=1 on the next cycle, then A2 is accepted. Pops deliver A1 then A2.
- Pass-through at full rate:
  - Stimulus: iReady[1]=1, push 32'd1..32'd100 to channel 1 back-to-back.
  - Required: oReady stays 1, cnt[1] never exceeds 1. Consumer sees 1..100 in order, each one cycle after acceptance.
- Simultaneous events:
  - Stimulus: channel 3 holds 1 word (32'h55), channel 0 holds 2 words. Same cycle: push 32'h66 to channel 3, iReady=1001.
  - Required: channel 3 pops 32'h55 and shows 32'h66 with oValid[3]=1. Channel 0 drops to 1 word.
- Random soak:
  - Stimulus: 10,000 cycles of random iValid/iS/iData/iReady, with a mid-run reset at cycle 5,000.
  - Required: per-channel scoreboard matches order exactly. No loss or duplication. All queues empty immediately after the reset.
